// File: rtl/id_scoreboard.sv
// Decode-stage register-hazard scoreboard: per-register in-flight write counters.
// Optional macro ID_SB_WB_BYPASS_EN: a source whose last pending write retires this cycle is not busy.
module id_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_REGS   = 32,
    parameter int NUM_SRC    = 2,
    parameter int CNT_W      = 2,
    parameter int TOT_W      = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rdy,
    input  logic                          issue_valid,
    input  logic [REG_ADDR_W-1:0]         issue_rd,
    input  logic                          issue_rd_we,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
    input  logic [NUM_SRC-1:0]            src_en,
    input  logic                          failed,
    input  logic                          wb_valid,
    input  logic [REG_ADDR_W-1:0]         wb_rd,
    output logic [NUM_SRC-1:0]            src_busy,
    output logic                          stall,
    output logic                          issue_fire,
    output logic [TOT_W-1:0]              pending_total,
    output logic                          err_underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [TOT_W-1:0] TOT_MAX  = {TOT_W{1'b1}};
    localparam logic [TOT_W-1:0] TOT_ONE  = TOT_W'(1);
    localparam logic [TOT_W-1:0] TOT_ZERO = {TOT_W{1'b0}};

    logic [CNT_W-1:0] cnt_r [NUM_REGS];
    logic [CNT_W-1:0] src_cnt_s [NUM_SRC];
    logic [CNT_W-1:0] rd_cnt_s;
    logic [CNT_W-1:0] wb_cnt_s;
    logic             ovf_stall_s;
    logic             inc_any_s;
    logic             dec_any_s;
    logic             same_reg_s;
    logic             tot_inc_s;
    logic             tot_dec_s;
    logic             underflow_s;

    // Counter lookups for each source, the destination and the retiring register (reg 0 reads as 0).
    always_comb begin
        rd_cnt_s = CNT_ZERO;
        wb_cnt_s = CNT_ZERO;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_cnt_s[i] = CNT_ZERO;
        end
        for (int r = 1; r < NUM_REGS; r++) begin
            rd_cnt_s = rd_cnt_s | (cnt_r[r] & {CNT_W{issue_rd == REG_ADDR_W'(r)}});
            wb_cnt_s = wb_cnt_s | (cnt_r[r] & {CNT_W{wb_rd == REG_ADDR_W'(r)}});
            for (int i = 0; i < NUM_SRC; i++) begin
                src_cnt_s[i] = src_cnt_s[i]
                             | (cnt_r[r] & {CNT_W{src_addr[i*REG_ADDR_W +: REG_ADDR_W] == REG_ADDR_W'(r)}});
            end
        end
    end

    // Per-source hazard, overflow stall and issue handshake.
    always_comb begin
        src_busy = {NUM_SRC{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
`ifdef ID_SB_WB_BYPASS_EN
            src_busy[i] = src_en[i] & (src_cnt_s[i] != CNT_ZERO)
                        & !((src_cnt_s[i] == CNT_ONE) & wb_valid
                            & (wb_rd == src_addr[i*REG_ADDR_W +: REG_ADDR_W]));
`else
            src_busy[i] = src_en[i] & (src_cnt_s[i] != CNT_ZERO);
`endif
        end
        ovf_stall_s = issue_valid & issue_rd_we & (issue_rd != {REG_ADDR_W{1'b0}})
                    & (rd_cnt_s == CNT_MAX) & !(wb_valid & (wb_rd == issue_rd));
        stall       = issue_valid & !failed & ((|src_busy) | ovf_stall_s);
        issue_fire  = issue_valid & !stall & !failed & rdy;
    end

    // Effective increment/decrement of the total; a same-register inc+dec cancels out.
    always_comb begin
        inc_any_s   = issue_fire & issue_rd_we & (issue_rd != {REG_ADDR_W{1'b0}})
                    & (32'(issue_rd) < NUM_REGS);
        dec_any_s   = wb_valid & (wb_rd != {REG_ADDR_W{1'b0}}) & (32'(wb_rd) < NUM_REGS);
        same_reg_s  = inc_any_s & dec_any_s & (issue_rd == wb_rd);
        tot_inc_s   = inc_any_s & !same_reg_s;
        tot_dec_s   = dec_any_s & !same_reg_s & (wb_cnt_s != CNT_ZERO);
        underflow_s = dec_any_s & !same_reg_s & (wb_cnt_s == CNT_ZERO);
    end

    // Per-register counters; register 0 is never tracked.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_r[r] <= CNT_ZERO;
            end
        end else if (rdy) begin
            cnt_r[0] <= CNT_ZERO;
            for (int r = 1; r < NUM_REGS; r++) begin
                case ({inc_any_s & (issue_rd == REG_ADDR_W'(r)), dec_any_s & (wb_rd == REG_ADDR_W'(r))})
                    2'b10:   cnt_r[r] <= cnt_r[r] + CNT_ONE;
                    2'b01:   cnt_r[r] <= (cnt_r[r] != CNT_ZERO) ? cnt_r[r] - CNT_ONE : CNT_ZERO;
                    default: cnt_r[r] <= cnt_r[r];
                endcase
            end
        end
    end

    // Saturating outstanding-write total and sticky underflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_total <= TOT_ZERO;
            err_underflow <= 1'b0;
        end else if (rdy) begin
            case ({tot_inc_s, tot_dec_s})
                2'b10:   pending_total <= (pending_total != TOT_MAX) ? pending_total + TOT_ONE : TOT_MAX;
                2'b01:   pending_total <= (pending_total != TOT_ZERO) ? pending_total - TOT_ONE : TOT_ZERO;
                default: pending_total <= pending_total;
            endcase
            err_underflow <= err_underflow | underflow_s;
        end
    end

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed self-checking bench for id_scoreboard (default parameters).
module tb_id_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       rdy;
    logic       issue_valid;
    logic [4:0] issue_rd;
    logic       issue_rd_we;
    logic [9:0] src_addr;
    logic [1:0] src_en;
    logic       failed;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic [1:0] src_busy;
    logic       stall;
    logic       issue_fire;
    logic [5:0] pending_total;
    logic       err_underflow;

    int tests = 0;
    int fails = 0;

    id_scoreboard dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rd_we(issue_rd_we),
        .src_addr(src_addr), .src_en(src_en), .failed(failed),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .src_busy(src_busy), .stall(stall), .issue_fire(issue_fire),
        .pending_total(pending_total), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic v, input logic [4:0] rd, input logic we,
                             input logic [4:0] s0, input logic [1:0] en);
        issue_valid = v;
        issue_rd    = rd;
        issue_rd_we = we;
        src_addr    = {5'd0, s0};
        src_en      = en;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] rd);
        wb_valid = v;
        wb_rd    = rd;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; failed = 1'b0;
        set_issue(1'b0, 5'd0, 1'b0, 5'd0, 2'b00);
        set_wb(1'b0, 5'd0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_pending", 32'(pending_total), 32'd0);
        chk("rst_err", 32'(err_underflow), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_fire", 32'(issue_fire), 32'd0);
        chk("rst_busy", 32'(src_busy), 32'd0);

        // RAW hazard on r5
        set_issue(1'b1, 5'd5, 1'b1, 5'd0, 2'b00); #1;
        chk("iss5_fire", 32'(issue_fire), 32'd1);
        tick();
        chk("iss5_pending", 32'(pending_total), 32'd1);
        set_issue(1'b1, 5'd6, 1'b1, 5'd5, 2'b01); #1;
        chk("raw_stall", 32'(stall), 32'd1);
        chk("raw_busy", 32'(src_busy), 32'd1);
        chk("raw_fire", 32'(issue_fire), 32'd0);
        tick();
        chk("raw_hold_pending", 32'(pending_total), 32'd1);
        set_wb(1'b1, 5'd5); #1;
`ifdef ID_SB_WB_BYPASS_EN
        chk("wb5_stall", 32'(stall), 32'd0);
        chk("wb5_fire", 32'(issue_fire), 32'd1);
        tick();
        set_wb(1'b0, 5'd0);
        set_issue(1'b0, 5'd0, 1'b0, 5'd0, 2'b00); #1;
        chk("wb5_pending", 32'(pending_total), 32'd1);
`else
        chk("wb5_stall", 32'(stall), 32'd1);
        chk("wb5_fire", 32'(issue_fire), 32'd0);
        tick();
        set_wb(1'b0, 5'd0); #1;
        chk("wb5_pending", 32'(pending_total), 32'd0);
        chk("post_wb5_stall", 32'(stall), 32'd0);
        chk("post_wb5_fire", 32'(issue_fire), 32'd1);
        tick();
        set_issue(1'b0, 5'd0, 1'b0, 5'd0, 2'b00); #1;
        chk("iss6_pending", 32'(pending_total), 32'd1);
`endif
        set_wb(1'b1, 5'd6); tick(); set_wb(1'b0, 5'd0); #1;
        chk("wb6_pending", 32'(pending_total), 32'd0);

        // r0 is never tracked
        set_issue(1'b1, 5'd0, 1'b1, 5'd0, 2'b01); #1;
        chk("r0_busy", 32'(src_busy), 32'd0);
        chk("r0_fire", 32'(issue_fire), 32'd1);
        tick();
        chk("r0_pending", 32'(pending_total), 32'd0);

        // Counter saturation on r7
        set_issue(1'b1, 5'd7, 1'b1, 5'd0, 2'b00);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("r7_fire", 32'(issue_fire), 32'd1);
            tick();
        end
        chk("r7_pending3", 32'(pending_total), 32'd3);
        chk("r7_ovf_stall", 32'(stall), 32'd1);
        chk("r7_ovf_fire", 32'(issue_fire), 32'd0);
        set_wb(1'b1, 5'd7); #1;
        chk("r7_wb_fire", 32'(issue_fire), 32'd1);
        tick();
        set_wb(1'b0, 5'd0); #1;
        chk("r7_wb_pending", 32'(pending_total), 32'd3);
        chk("r7_still_full", 32'(stall), 32'd1);
        set_issue(1'b0, 5'd0, 1'b0, 5'd0, 2'b00);
        set_wb(1'b1, 5'd7);
        repeat (3) tick();
        set_wb(1'b0, 5'd0); #1;
        chk("r7_drain", 32'(pending_total), 32'd0);

        // Same-cycle issue and retire on r3
        set_issue(1'b1, 5'd3, 1'b1, 5'd0, 2'b00); tick();
        chk("r3_pending1", 32'(pending_total), 32'd1);
        set_wb(1'b1, 5'd3); #1;
        chk("r3_both_fire", 32'(issue_fire), 32'd1);
        tick();
        set_wb(1'b0, 5'd0);
        set_issue(1'b1, 5'd0, 1'b0, 5'd3, 2'b01); #1;
        chk("r3_pending_same", 32'(pending_total), 32'd1);
        chk("r3_still_busy", 32'(src_busy), 32'd1);
        set_issue(1'b0, 5'd0, 1'b0, 5'd0, 2'b00);
        set_wb(1'b1, 5'd3); tick(); set_wb(1'b0, 5'd0); #1;
        chk("r3_drain", 32'(pending_total), 32'd0);
        chk("r3_no_err", 32'(err_underflow), 32'd0);

        // Underflow on r9 is sticky
        set_wb(1'b1, 5'd9); tick(); set_wb(1'b0, 5'd0); #1;
        chk("uf_set", 32'(err_underflow), 32'd1);
        chk("uf_pending", 32'(pending_total), 32'd0);
        repeat (3) tick();
        chk("uf_sticky", 32'(err_underflow), 32'd1);

        // Mispredict suppresses issue but not retire
        set_issue(1'b1, 5'd8, 1'b1, 5'd0, 2'b00); tick();
        failed = 1'b1;
        set_issue(1'b1, 5'd4, 1'b1, 5'd0, 2'b00);
        set_wb(1'b1, 5'd8); #1;
        chk("fail_fire", 32'(issue_fire), 32'd0);
        chk("fail_stall", 32'(stall), 32'd0);
        tick();
        failed = 1'b0;
        set_wb(1'b0, 5'd0);
        set_issue(1'b1, 5'd0, 1'b0, 5'd4, 2'b01); #1;
        chk("fail_r4_idle", 32'(src_busy), 32'd0);
        chk("fail_pending", 32'(pending_total), 32'd0);

        // rdy low freezes state
        rdy = 1'b0;
        set_issue(1'b1, 5'd10, 1'b1, 5'd0, 2'b00); #1;
        chk("frz_fire", 32'(issue_fire), 32'd0);
        tick();
        chk("frz_pending", 32'(pending_total), 32'd0);
        rdy = 1'b1;

        // Reset mid-operation
        set_issue(1'b1, 5'd11, 1'b1, 5'd0, 2'b00); tick(); tick();
        chk("pre_rst_pending", 32'(pending_total), 32'd2);
        set_issue(1'b1, 5'd12, 1'b1, 5'd11, 2'b01); #1;
        chk("pre_rst_stall", 32'(stall), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0; #1;
        chk("post_rst_pending", 32'(pending_total), 32'd0);
        chk("post_rst_stall", 32'(stall), 32'd0);
        chk("post_rst_err", 32'(err_underflow), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
